// File: rtl/validador_pkg.sv
// Shared definitions for the move validator: FSM states, player encodings
// and the default board size.
package validador_pkg;

  typedef enum logic [1:0] {
    ESPERA   = 2'd0,
    VERIFICA = 2'd1,
    EMITE    = 2'd2
  } estado_t;

  localparam logic JUGADOR_A = 1'b0;
  localparam logic JUGADOR_B = 1'b1;

  localparam int CELDAS_DEF = 16;

endpackage

// File: rtl/decodificador_onehot.sv
// Combinational index-to-one-hot decoder; an index outside the board or a
// low enable yields an all-zero vector.
module decodificador_onehot #(
  parameter int CELDAS    = 16,
  parameter int ANCHO_POS = $clog2(CELDAS)
) (
  input  logic [ANCHO_POS-1:0] i_indice,
  input  logic                 i_habilitar,
  output logic [CELDAS-1:0]    o_onehot
);

  for (genvar g = 0; g < CELDAS; g++) begin : g_celda
    assign o_onehot[g] = i_habilitar && (i_indice == ANCHO_POS'(g));
  end

endmodule

// File: rtl/validador_jugada.sv
// Board-game move validator: takes a move request, checks it against the
// occupancy/owner maps and turn, and commits or refuses it two cycles later.
module validador_jugada
  import validador_pkg::*;
#(
  parameter int CELDAS    = CELDAS_DEF,
  parameter int ANCHO_POS = $clog2(CELDAS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 limpiar,
  input  logic                 jugada_valida,
  output logic                 listo,
  input  logic [ANCHO_POS-1:0] posicion_jugada,
  input  logic                 jugador,
  output logic [CELDAS-1:0]    habilitar_jugada,
  output logic [CELDAS-1:0]    ocupado,
  output logic [CELDAS-1:0]    dueno,
  output logic                 turno,
  output logic                 jugada_aceptada,
  output logic                 jugada_rechazada,
  output logic                 tablero_lleno,
  output logic [ANCHO_POS:0]   conteo_jugadas
);

  localparam logic [ANCHO_POS:0] L_CELDAS = (ANCHO_POS+1)'(CELDAS);
  localparam logic [ANCHO_POS:0] L_UNO    = (ANCHO_POS+1)'(1);

  estado_t               r_estado, w_estado_sig;
  logic [ANCHO_POS-1:0]  r_pos;
  logic                  r_jugador;
  logic [CELDAS-1:0]     r_ocupado, r_dueno, r_habilitar;
  logic                  r_turno, r_aceptada, r_rechazada;
  logic [ANCHO_POS:0]    r_conteo;

  logic [CELDAS-1:0]     w_onehot;
  logic                  w_en_verifica, w_toma, w_en_rango, w_libre, w_lleno, w_legal;

  assign w_en_verifica = (r_estado == VERIFICA);
  assign w_toma        = jugada_valida && (r_estado == ESPERA);

  decodificador_onehot #(
    .CELDAS    (CELDAS),
    .ANCHO_POS (ANCHO_POS)
  ) u_dec (
    .i_indice    (r_pos),
    .i_habilitar (w_en_verifica),
    .o_onehot    (w_onehot)
  );

  // Out-of-range positions decode to zero, so the occupancy test alone
  // cannot catch them; the explicit range check covers that case.
  assign w_en_rango = ({1'b0, r_pos} < L_CELDAS);
  assign w_libre    = ~|(w_onehot & r_ocupado);
  assign w_lleno    = (r_conteo == L_CELDAS);
  assign w_legal    = w_en_rango && w_libre && (r_jugador == r_turno) && !w_lleno;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_estado <= ESPERA;
    else        r_estado <= w_estado_sig;
  end

  always_comb begin
    w_estado_sig = r_estado;
    if (limpiar) begin
      w_estado_sig = ESPERA;
    end else begin
      case (r_estado)
        ESPERA:   if (jugada_valida) w_estado_sig = VERIFICA;
        VERIFICA: w_estado_sig = EMITE;
        EMITE:    w_estado_sig = ESPERA;
        default:  w_estado_sig = ESPERA;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos       <= '0;
      r_jugador   <= JUGADOR_A;
      r_ocupado   <= '0;
      r_dueno     <= '0;
      r_habilitar <= '0;
      r_turno     <= JUGADOR_A;
      r_aceptada  <= 1'b0;
      r_rechazada <= 1'b0;
      r_conteo    <= '0;
    end else if (limpiar) begin
      r_ocupado   <= '0;
      r_dueno     <= '0;
      r_habilitar <= '0;
      r_turno     <= JUGADOR_A;
      r_aceptada  <= 1'b0;
      r_rechazada <= 1'b0;
      r_conteo    <= '0;
    end else begin
      r_aceptada  <= 1'b0;
      r_rechazada <= 1'b0;
      r_habilitar <= '0;
      if (w_toma) begin
        r_pos     <= posicion_jugada;
        r_jugador <= jugador;
      end
      // Commit happens on the VERIFICA->EMITE edge so every effect is visible in EMITE.
      if (w_en_verifica) begin
        if (w_legal) begin
          r_aceptada  <= 1'b1;
          r_habilitar <= w_onehot;
          r_ocupado   <= r_ocupado | w_onehot;
          r_dueno     <= (r_jugador == JUGADOR_B) ? (r_dueno | w_onehot) : (r_dueno & ~w_onehot);
          r_turno     <= (r_turno == JUGADOR_A) ? JUGADOR_B : JUGADOR_A;
          r_conteo    <= r_conteo + L_UNO;
        end else begin
          r_rechazada <= 1'b1;
        end
      end
    end
  end

  assign listo            = (r_estado == ESPERA);
  assign habilitar_jugada = r_habilitar;
  assign ocupado          = r_ocupado;
  assign dueno            = r_dueno;
  assign turno            = r_turno;
  assign jugada_aceptada  = r_aceptada;
  assign jugada_rechazada = r_rechazada;
  assign tablero_lleno    = w_lleno;
  assign conteo_jugadas   = r_conteo;

endmodule

// File: doc/validador_jugada.md
VALIDADOR_JUGADA -- requirements
Module: validador_jugada

Interface
REQ-001 Parameter CELDAS, default 16: number of board cells, legal range 4..64.
REQ-002 Parameter ANCHO_POS, default $clog2(CELDAS): width of the position field.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 limpiar  input  1  synchronous board clear (new game).
REQ-006 jugada_valida  input  1  move request valid.
REQ-007 listo  output  1  block ready to accept a move request.
REQ-008 posicion_jugada  input  ANCHO_POS  requested cell index.
REQ-009 jugador  input  1  requesting player (0 = jugador A, 1 = jugador B).
REQ-010 habilitar_jugada  output  CELDAS  one-hot write strobe for the accepted cell.
REQ-011 ocupado  output  CELDAS  occupancy map; bit i = cell i taken.
REQ-012 dueno  output  CELDAS  owner map; bit i = player of cell i, meaningful only where ocupado[i] = 1.
REQ-013 turno  output  1  player whose move is expected next.
REQ-014 jugada_aceptada  output  1  one-cycle pulse: move committed.
REQ-015 jugada_rechazada  output  1  one-cycle pulse: move refused.
REQ-016 tablero_lleno  output  1  all CELDAS cells occupied.
REQ-017 conteo_jugadas  output  ANCHO_POS+1  number of committed moves.

Function
REQ-018 FSM states: ESPERA, VERIFICA, EMITE.
REQ-019 listo SHALL be 1 only in ESPERA.
REQ-020 Handshake: a request is taken in the cycle jugada_valida = 1 and listo = 1; posicion_jugada and jugador are registered then, and the state goes to VERIFICA.
REQ-021 Inputs other than limpiar are ignored outside ESPERA.
REQ-022 VERIFICA lasts exactly one cycle and then goes to EMITE; EMITE lasts exactly one cycle and then returns to ESPERA.
REQ-023 A move is illegal if the position is >= CELDAS, the cell is occupied, jugador != turno, or tablero_lleno = 1.
REQ-024 The result is registered so that in the EMITE cycle (handshake cycle + 2) exactly one of jugada_aceptada or jugada_rechazada is 1.
REQ-025 On accept, in the EMITE cycle: habilitar_jugada has only bit pos set, ocupado[pos] = 1, dueno[pos] = jugador, turno toggles, and conteo_jugadas increments by 1.
REQ-026 On reject, habilitar_jugada = 0 and ocupado, dueno, turno and conteo_jugadas are unchanged.
REQ-027 habilitar_jugada, jugada_aceptada and jugada_rechazada are 0 in every cycle other than EMITE.
REQ-028 tablero_lleno = 1 exactly when conteo_jugadas == CELDAS; it is derived from the registered count.
REQ-029 limpiar has priority over any state and any request; the next edge sets ocupado, dueno, conteo_jugadas, pulses and habilitar_jugada to 0, turno to 0, and the state to ESPERA.
REQ-030 A request pending together with limpiar is discarded.
REQ-031 Minimum request spacing is 3 cycles, and back-to-back requests are accepted every 3 cycles.

Reset
REQ-032 rst_n = 0 immediately forces state ESPERA and all outputs and registers to 0; listo becomes 1 once the state is ESPERA.
REQ-033 Reset in the middle of a request abandons the request, and no pulse is emitted.
REQ-034 Release of rst_n is synchronised by the integrating design, and the first request is legal on the first edge after release.

Structure
REQ-035 A shared package validador_pkg SHALL hold the FSM state enum, the player encodings (JUGADOR_A = 0, JUGADOR_B = 1) and the default CELDAS.
REQ-036 One sub-module SHALL be used: decodificador_onehot, parametrised by CELDAS and purely combinational (index + enable -> one-hot, zero for out-of-range index).
REQ-037 All other logic (FSM, maps, counter) SHALL reside in validador_jugada.

Verification
REQ-038 Reset, then request pos=5 jugador=0 -> at cycle t+2: jugada_aceptada=1, habilitar_jugada=16'h0020, ocupado=16'h0020, turno=1, conteo=1.
REQ-039 After REQ-038, request pos=5 jugador=1 -> jugada_rechazada=1, habilitar_jugada=0, maps unchanged.
REQ-040 After reset, request pos=3 jugador=1 (wrong turn) -> rejected, turno stays 0.
REQ-041 Fill all 16 cells alternating players -> tablero_lleno=1, conteo=16, dueno=16'hAAAA for the sequence pos i by player i%2; a 17th request is rejected.
REQ-042 Assert limpiar during VERIFICA of a legal move -> no pulse, maps=0, turno=0, listo=1 next cycle.
REQ-043 With CELDAS=9, request pos=12 -> rejected; assert rst_n=0 mid-request -> outputs 0 immediately with no pulse.
